// File: rtl/risc_pkg.sv
// Shared types and encodings for the 16-bit RISC sequencing controller.
// The controller FSM states, opcode/condition fields, memory commands and write-back selects.
package risc_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_UPC, S_DEC,
        S_MOVI, S_MB, S_MC, S_WB,
        S_AB, S_AA, S_AC,
        S_LA, S_LC, S_MA, S_MR, S_LW,
        S_SA, S_SC, S_MAS, S_SB, S_SC2, S_MW,
        S_BR, S_HALT
    } state_t;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVSH = 2'b00;
    localparam logic [1:0] OP_MOVI  = 2'b10;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_MVN   = 2'b11;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/risc_branch_eval.sv
// Branch condition evaluator: maps the condition code (Rn field) and datapath flags to taken.
module risc_branch_eval (
    input  logic [2:0] cond_i,
    input  logic       flag_n_i,
    input  logic       flag_z_i,
    input  logic       flag_v_i,
    output logic       taken_o
);
    import risc_pkg::*;

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_AL: taken_o = 1'b1;
            COND_EQ: taken_o = flag_z_i;
            COND_NE: taken_o = ~flag_z_i;
            COND_LT: taken_o = flag_n_i ^ flag_v_i;
            COND_LE: taken_o = (flag_n_i ^ flag_v_i) | flag_z_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle controller: owns PC, IR, data-address register and the main FSM,
// and drives the datapath strobes. All outputs are Moore (state + registered IR).
module risc_seq_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] dp_c,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_v,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [4:0]        dbg_state_o
);
    import risc_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic              addr_sel;
    logic              br_taken;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign alu_op      = op;
    assign shift       = ir_q[4:3];
    assign sximm5      = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign sximm8      = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign mem_addr    = addr_sel ? pc_q : addr_q;
    assign mem_wdata   = dp_c;
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

    risc_branch_eval u_branch_eval (
        .cond_i   (rn),
        .flag_n_i (flag_n),
        .flag_z_i (flag_z),
        .flag_v_i (flag_v),
        .taken_o  (br_taken)
    );

    // Reset wins over everything, so a pending handshake is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RST;
            pc_q      <= RESET_PC;
            addr_q    <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        mem_cmd   = MNONE;
        addr_sel  = 1'b1;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;

        case (state_q)
            S_RST: begin
                pc_d    = RESET_PC;
                state_d = S_IF1;
            end
            S_IF1: begin
                mem_cmd = MREAD;
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    state_d = S_UPC;
                end
            end
            S_UPC: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOVI) begin
                            state_d = S_MOVI;
                        end else if (op == OP_MOVSH) begin
                            state_d = S_MB;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
                        end
                    end
                    OPC_ALU:  state_d = S_AB;
                    OPC_LDR:  state_d = S_LA;
                    OPC_STR:  state_d = S_SA;
                    OPC_BR:   state_d = S_BR;
                    OPC_HALT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MOVI: begin
                write    = 1'b1;
                writenum = rn;
                vsel     = VSEL_IMM8;
                state_d  = S_IF1;
            end
            S_MB: begin
                loadb   = 1'b1;
                readnum = rm;
                asel    = 1'b1;
                state_d = S_MC;
            end
            S_MC: begin
                loadc   = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                write    = 1'b1;
                writenum = rd;
                vsel     = VSEL_C;
                state_d  = S_IF1;
            end
            S_AB: begin
                loadb   = 1'b1;
                readnum = rm;
                state_d = (op == OP_MVN) ? S_AC : S_AA;
            end
            S_AA: begin
                loada   = 1'b1;
                readnum = rn;
                state_d = S_AC;
            end
            S_AC: begin
                // CMP only updates the status register and skips write-back.
                if (op == OP_CMP) begin
                    loads   = 1'b1;
                    state_d = S_IF1;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WB;
                end
            end
            S_LA, S_SA: begin
                loada   = 1'b1;
                readnum = rn;
                bsel    = 1'b1;
                state_d = (state_q == S_LA) ? S_LC : S_SC;
            end
            S_LC, S_SC: begin
                loadc   = 1'b1;
                state_d = (state_q == S_LC) ? S_MA : S_MAS;
            end
            S_MA, S_MAS: begin
                addr_d  = dp_c[ADDR_W-1:0];
                state_d = (state_q == S_MA) ? S_MR : S_SB;
            end
            S_MR: begin
                mem_cmd  = MREAD;
                addr_sel = 1'b0;
                if (mem_ready) state_d = S_LW;
            end
            S_LW: begin
                write    = 1'b1;
                writenum = rd;
                vsel     = VSEL_MDATA;
                state_d  = S_IF1;
            end
            S_SB: begin
                loadb   = 1'b1;
                readnum = rd;
                state_d = S_SC2;
            end
            S_SC2: begin
                loadc   = 1'b1;
                asel    = 1'b1;
                state_d = S_MW;
            end
            S_MW: begin
                mem_cmd  = MWRITE;
                addr_sel = 1'b0;
                if (mem_ready) state_d = S_IF1;
            end
            S_BR: begin
                // PC already points past the branch, so the offset is relative to instr+1.
                if (br_taken) pc_d = pc_q + sximm8[ADDR_W-1:0];
                state_d = S_IF1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Bench for risc_seq_ctrl: behavioural memory with programmable latency, directed
// programs, and a scoreboard of expected register writes and memory writes.
module tb_risc_seq_ctrl;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] dp_c = '0;
    logic        flag_n = 1'b0, flag_z = 1'b0, flag_v = 1'b0;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, alu_op, shift;
    logic [15:0] sximm5, sximm8;
    logic [8:0]  pc;
    logic        halted, illegal;
    logic [4:0]  dbg_state;

    risc_seq_ctrl dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dp_c(dp_c), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .alu_op(alu_op), .shift(shift), .sximm5(sximm5),
        .sximm8(sximm8), .pc(pc), .halted(halted), .illegal(illegal),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural memory: fetch and data accesses have separate latencies
    logic [15:0] mem [0:511];
    int   hs_cnt = 0;
    int   fetch_delay = 0, data_delay = 0;
    logic is_fetch;

    assign mem_rdata = mem[mem_addr];
    assign is_fetch  = (mem_cmd == MREAD) && (mem_addr == pc);
    assign mem_ready = (mem_cmd != MNONE) && (hs_cnt >= (is_fetch ? fetch_delay : data_delay));

    always @(posedge clk) begin
        if (reset || mem_cmd == MNONE || mem_ready) hs_cnt <= 0;
        else hs_cnt <= hs_cnt + 1;
    end

    // scoreboard state
    logic [4:0]  exp_q[$];
    logic [24:0] exp_mw_q[$];
    int n_checks = 0, n_fail = 0;
    int wr_count = 0, mwrite_cycles = 0, dread_cycles = 0;
    int last_wr_cyc = 0, last_dread_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a write-back or a memory write
    always @(negedge clk) begin
        logic [4:0]  e;
        logic [24:0] m;
        if (!reset) begin
            if (write) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got writenum=%0d vsel=%0d, expected no write", writenum, vsel);
                end else begin
                    e = exp_q.pop_front();
                    check("writeback", {27'd0, writenum, vsel}, {27'd0, e});
                end
            end
            if (mem_cmd == MREAD && mem_addr == dp_c[8:0] && mem_addr != pc) begin
                dread_cycles++;
                last_dread_cyc = cyc;
            end
            if (mem_cmd == MWRITE) begin
                mwrite_cycles++;
                if (mem_ready) begin
                    if (exp_mw_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_mwrite: got addr=0x%0h data=0x%0h, expected none", mem_addr, mem_wdata);
                    end else begin
                        m = exp_mw_q.pop_front();
                        check("mwrite", {7'd0, mem_addr, mem_wdata}, {7'd0, m});
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
    endtask

    task automatic start(input int fd, input int dd);
        reset = 1'b1;
        fetch_delay = fd;
        data_delay = dd;
        cycles(2);
        check("rst_mem_cmd", {30'd0, mem_cmd}, MNONE);
        check("rst_write", {31'd0, write}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_illegal", {31'd0, illegal}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            cycles(1);
            n++;
        end
        check(name, {31'd0, halted}, 1);
    endtask

    typedef struct packed {
        logic [2:0] cond;
        logic       n, z, v;
        logic [7:0] imm;
        logic [8:0] exp_pc;
    } br_vec_t;

    br_vec_t     br_tab [12];
    logic [15:0] ill_ins [5];
    logic        ill_exp [5];

    initial begin
        int w0, d0, m0;
        logic [15:0] ins;

        br_tab[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h05, 9'h006};
        br_tab[1]  = '{3'd1, 1'b0, 1'b1, 1'b0, 8'hFE, 9'h1FF};
        br_tab[2]  = '{3'd1, 1'b0, 1'b0, 1'b0, 8'hFE, 9'h001};
        br_tab[3]  = '{3'd2, 1'b0, 1'b0, 1'b0, 8'h05, 9'h006};
        br_tab[4]  = '{3'd2, 1'b0, 1'b1, 1'b0, 8'h05, 9'h001};
        br_tab[5]  = '{3'd3, 1'b1, 1'b0, 1'b0, 8'h05, 9'h006};
        br_tab[6]  = '{3'd3, 1'b1, 1'b0, 1'b1, 8'h05, 9'h001};
        br_tab[7]  = '{3'd4, 1'b0, 1'b1, 1'b0, 8'h05, 9'h006};
        br_tab[8]  = '{3'd4, 1'b0, 1'b0, 1'b1, 8'h05, 9'h006};
        br_tab[9]  = '{3'd4, 1'b1, 1'b0, 1'b1, 8'h05, 9'h001};
        br_tab[10] = '{3'd5, 1'b1, 1'b1, 1'b0, 8'h05, 9'h001};
        br_tab[11] = '{3'd7, 1'b1, 1'b1, 1'b0, 8'h05, 9'h001};

        ill_ins[0] = 16'h0000; ill_exp[0] = 1'b1;
        ill_ins[1] = 16'h4000; ill_exp[1] = 1'b1;
        ill_ins[2] = 16'hC800; ill_exp[2] = 1'b1;
        ill_ins[3] = 16'hD800; ill_exp[3] = 1'b1;
        ill_ins[4] = 16'hE000; ill_exp[4] = 1'b0;

        // MOV R0,#7 with zero-latency memory: write-back in the 4th cycle after release
        clear_mem();
        mem[0] = 16'hD007;
        exp_q.push_back({3'd0, VSEL_IMM8});
        start(0, 0);
        cycles(4);
        check("t1_write", {31'd0, write}, 1);
        check("t1_writenum", {29'd0, writenum}, 0);
        check("t1_vsel", {30'd0, vsel}, VSEL_IMM8);
        check("t1_pc", {23'd0, pc}, 1);
        wait_halt("t1_halt", 30);

        // LDR R1,[R0] with 3 wait cycles on the data read
        clear_mem();
        mem[0] = 16'h6020;
        dp_c = 16'h3155;
        d0 = dread_cycles;
        exp_q.push_back({3'd1, VSEL_MDATA});
        start(0, 3);
        wait_halt("t2_halt", 60);
        check("t2_read_cycles", dread_cycles - d0, 4);
        check("t2_write_latency", last_wr_cyc - last_dread_cyc, 1);

        // STR R1,[R0,#1]: exactly one MWRITE cycle
        clear_mem();
        mem[0] = 16'h8021;
        dp_c = 16'h5E3C;
        m0 = mwrite_cycles;
        exp_mw_q.push_back({9'h03C, 16'h5E3C});
        start(1, 0);
        cycles(4);
        check("t3_sximm5", {16'd0, sximm5}, 16'h0001);
        wait_halt("t3_halt", 60);
        check("t3_mwrite_cycles", mwrite_cycles - m0, 1);

        // mixed program: ADD, CMP, MVN, MOV shifted, MOVI, STR, LDR, HALT
        clear_mem();
        mem[0] = 16'hA140;
        mem[1] = 16'hA900;
        mem[2] = 16'hB860;
        mem[3] = 16'hC081;
        mem[4] = 16'hD509;
        mem[5] = 16'h8021;
        mem[6] = 16'h60C0;
        dp_c = 16'h0077;
        exp_q.push_back({3'd2, VSEL_C});
        exp_q.push_back({3'd3, VSEL_C});
        exp_q.push_back({3'd4, VSEL_C});
        exp_q.push_back({3'd5, VSEL_IMM8});
        exp_mw_q.push_back({9'h077, 16'h0077});
        exp_q.push_back({3'd6, VSEL_MDATA});
        start(1, 2);
        wait_halt("prog_halt", 300);
        check("prog_pc", {23'd0, pc}, 8);
        check("prog_exp_q_empty", exp_q.size(), 0);
        check("prog_mw_q_empty", exp_mw_q.size(), 0);

        // branches: condition table, including the wrap-around case
        dp_c = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            clear_mem();
            ins = {3'b001, 2'b00, br_tab[i].cond, br_tab[i].imm};
            mem[0] = ins;
            flag_n = br_tab[i].n;
            flag_z = br_tab[i].z;
            flag_v = br_tab[i].v;
            start(0, 0);
            cycles(4);
            check($sformatf("br%0d_sximm8", i), {16'd0, sximm8}, {16'd0, {8{br_tab[i].imm[7]}}, br_tab[i].imm});
            cycles(1);
            check($sformatf("br%0d_pc", i), {23'd0, pc}, {23'd0, br_tab[i].exp_pc});
            wait_halt($sformatf("br%0d_halt", i), 30);
        end
        flag_n = 1'b0;
        flag_z = 1'b0;
        flag_v = 1'b0;

        // undefined opcodes trap; HALT itself does not
        for (int i = 0; i < 5; i++) begin
            clear_mem();
            mem[0] = ill_ins[i];
            start(0, 0);
            cycles(4);
            check($sformatf("ill%0d_halted", i), {31'd0, halted}, 1);
            check($sformatf("ill%0d_illegal", i), {31'd0, illegal}, {31'd0, ill_exp[i]});
            check($sformatf("ill%0d_pc", i), {23'd0, pc}, 1);
            if (i == 0) begin
                cycles(20);
                check("ill_frozen_pc", {23'd0, pc}, 1);
                check("ill_frozen_halted", {31'd0, halted}, 1);
                check("ill_frozen_illegal", {31'd0, illegal}, 1);
                check("ill_frozen_mem_cmd", {30'd0, mem_cmd}, MNONE);
            end
        end

        // reset during an LDR data-read wait aborts with no write-back
        clear_mem();
        mem[0] = 16'h6020;
        dp_c = 16'h3155;
        w0 = wr_count;
        start(0, 10);
        cycles(7);
        check("t6_mr_cmd", {30'd0, mem_cmd}, MREAD);
        check("t6_mr_addr", {23'd0, mem_addr}, 9'h155);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("t6_rst_cmd", {30'd0, mem_cmd}, MNONE);
        check("t6_rst_write", {31'd0, write}, 0);
        mem[0] = 16'hE000;
        reset = 1'b0;
        cycles(1);
        check("t6_refetch_cmd", {30'd0, mem_cmd}, MREAD);
        check("t6_refetch_addr", {23'd0, mem_addr}, 0);
        wait_halt("t6_halt", 30);
        check("t6_no_write", wr_count - w0, 0);

        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_mw_q_empty", exp_mw_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
